// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, special instruction encodings, fetch FSM states.
package mips_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned INS_W = 32;

    localparam logic [INS_W-1:0] NOP_INS  = 32'h0000_0000;
    localparam logic [INS_W-1:0] HALT_INS = 32'hFC00_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: control inputs, ins_mem fetch path and IF/ID outputs.
interface if_stage_if;
    import mips_pkg::*;

    logic             stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic [INS_W-1:0] inscode;
    logic [XLEN-1:0]  pc;
    logic [INS_W-1:0] if_id_ins;
    logic [XLEN-1:0]  if_id_pc4;
    logic             if_id_valid;
    logic             halted;
    logic             fetch_err;

    // Driver side: hazard/branch logic plus instruction memory.
    modport master (
        output stall, redirect_valid, redirect_pc, inscode,
        input  pc, if_id_ins, if_id_pc4, if_id_valid, halted, fetch_err
    );

    // Fetch stage itself.
    modport slave (
        input  stall, redirect_valid, redirect_pc, inscode,
        output pc, if_id_ins, if_id_pc4, if_id_valid, halted, fetch_err
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush inserts a bubble and wins over load, otherwise holds.
module if_id_reg
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_flush,
    input  logic [INS_W-1:0] i_ins,
    input  logic [XLEN-1:0]  i_pc4,
    output logic [INS_W-1:0] o_ins,
    output logic [XLEN-1:0]  o_pc4,
    output logic             o_valid
);
    logic [INS_W-1:0] r_ins;
    logic [XLEN-1:0]  r_pc4;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ins   <= NOP_INS;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_ins   <= NOP_INS;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_ins   <= i_ins;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_ins   = r_ins;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetch FSM (BOOT/RUN/HALT), redirects, stalls and range checks.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     MEM_BYTES = 37
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.slave   bus
);
    fetch_state_e    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_fetch_err, w_fetch_err_nxt;
    logic            r_halted;
    logic            w_load, w_flush, w_pc_bad;
    logic [XLEN-1:0] w_pc4;

    assign w_pc4 = r_pc + XLEN'(4);
    // Word fetch needs all four bytes in range; 33-bit sum so the top of the address space cannot wrap.
    assign w_pc_bad = (r_pc[1:0] != 2'b00) ||
                      (({1'b0, r_pc} + 33'd3) >= 33'(MEM_BYTES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= BOOT;
            r_pc        <= RESET_PC;
            r_fetch_err <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_fetch_err <= w_fetch_err_nxt;
            r_halted    <= (w_state_nxt == HALT);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_fetch_err_nxt = r_fetch_err;
        w_load          = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = bus.redirect_pc;
                    w_flush  = 1'b1;
                end else if (bus.stall) begin
                    w_state_nxt = RUN;
                end else if (w_pc_bad) begin
                    w_fetch_err_nxt = 1'b1;
                    w_flush         = 1'b1;
                    w_state_nxt     = HALT;
                end else if (bus.inscode == HALT_INS) begin
                    w_flush     = 1'b1;
                    w_state_nxt = HALT;
                end else begin
                    w_load   = 1'b1;
                    w_pc_nxt = w_pc4;
                end
            end
            HALT: begin
                // A redirect means the halt/error came from a wrong-path fetch.
                if (bus.redirect_valid) begin
                    w_pc_nxt        = bus.redirect_pc;
                    w_fetch_err_nxt = 1'b0;
                    w_flush         = 1'b1;
                    w_state_nxt     = RUN;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_ins   (bus.inscode),
        .i_pc4   (w_pc4),
        .o_ins   (bus.if_id_ins),
        .o_pc4   (bus.if_id_pc4),
        .o_valid (bus.if_id_valid)
    );

    assign bus.pc        = r_pc;
    assign bus.halted    = r_halted;
    assign bus.fetch_err = r_fetch_err;
endmodule
